unidad_salto: RTL and testbench



---
 rtl/unidad_salto_pkg.sv | 14 +
 rtl/unidad_salto_calc_destino.sv | 25 ++
 rtl/unidad_salto.sv | 107 ++++++++++
 tb/tb_unidad_salto.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/unidad_salto_pkg.sv
// rtl/unidad_salto_pkg.sv - shared core definitions for branch resolution and PC update
package unidad_salto_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          J_TARGET_W       = 26;
    localparam int          IMM_W            = 16;

endpackage

// File: rtl/unidad_salto_calc_destino.sv
// rtl/unidad_salto_calc_destino.sv - combinational branch and jump target calculation
// Ports:
//   pc_id     : PC of the instruction in ID
//   inmediato : sign-extended branch offset (in words)
//   destino_j : J-type target field
//   rama      : branch target, pc_id + 4 + (inmediato << 2)
//   salto     : jump target, {pc4[31:28], destino_j, 2'b00}
module calc_destino
    import unidad_salto_pkg::*;
(
    input  logic [31:0]           pc_id,
    input  logic [31:0]           inmediato,
    input  logic [J_TARGET_W-1:0] destino_j,
    output logic [31:0]           rama,
    output logic [31:0]           salto
);

    logic [31:0] pc4;

    // All sums are modulo 2^32; the top two offset bits fall off in the shift.
    assign pc4   = pc_id + PC_INC;
    assign rama  = pc4 + {inmediato[29:0], 2'b00};
    assign salto = {pc4[31:28], destino_j, 2'b00};

endmodule

// File: rtl/unidad_salto.sv
// rtl/unidad_salto.sv - branch resolution, PC register and redirect/wait counters
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   Comparador_Salida    : ID comparator, 1 = branch operands equal
//   es_beq/es_bne/es_jump: decoded control (priority jump > beq > bne)
//   operandos_listos     : 0 = branch operands not yet forwardable
//   stall_ext            : global stall from hazard unit, freezes this block
//   pc_id, inmediato, destino_j : ID-stage PC and target fields
//   pc                   : registered fetch PC
//   flush_if_id          : IF/ID captures a NOP at the next edge
//   stall_id             : hold IF/ID and PC while a branch waits for operands
//   cnt_saltos           : saturating count of taken redirects
//   cnt_esperas          : saturating count of operand-wait cycles
module unidad_salto
    import unidad_salto_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Comparador_Salida,
    input  logic                  es_beq,
    input  logic                  es_bne,
    input  logic                  es_jump,
    input  logic                  operandos_listos,
    input  logic                  stall_ext,
    input  logic [31:0]           pc_id,
    input  logic [31:0]           inmediato,
    input  logic [J_TARGET_W-1:0] destino_j,
    output logic [31:0]           pc,
    output logic                  flush_if_id,
    output logic                  stall_id,
    output logic [CNT_W-1:0]      cnt_saltos,
    output logic [CNT_W-1:0]      cnt_esperas
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    estado_t     estado, estado_sig;
    logic [31:0] pc_sig;
    logic [31:0] rama, salto;
    logic        es_rama, tomado;
    logic        inc_saltos, inc_esperas;

    calc_destino u_calc_destino (
        .pc_id     (pc_id),
        .inmediato (inmediato),
        .destino_j (destino_j),
        .rama      (rama),
        .salto     (salto)
    );

    // Jump has already been filtered out, so BEQ wins over BNE here.
    assign es_rama = ~es_jump & (es_beq | es_bne);
    assign tomado  = es_beq ? Comparador_Salida : ~Comparador_Salida;

    // RUN and ESPERA resolve identically once operands are ready; the state
    // records that a branch is parked in ID waiting for forwarding.
    always_comb begin
        estado_sig  = estado;
        pc_sig      = pc;
        flush_if_id = 1'b0;
        stall_id    = 1'b0;
        inc_saltos  = 1'b0;
        inc_esperas = 1'b0;
        if (!reset && !stall_ext) begin
            if (es_jump) begin
                pc_sig      = salto;
                flush_if_id = 1'b1;
                inc_saltos  = 1'b1;
                estado_sig  = RUN;
            end else if (es_rama && !operandos_listos) begin
                stall_id    = 1'b1;
                inc_esperas = 1'b1;
                estado_sig  = ESPERA;
            end else if (es_rama && tomado) begin
                pc_sig      = rama;
                flush_if_id = 1'b1;
                inc_saltos  = 1'b1;
                estado_sig  = RUN;
            end else begin
                pc_sig      = pc + PC_INC;
                estado_sig  = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= RUN;
            pc          <= RESET_PC;
            cnt_saltos  <= '0;
            cnt_esperas <= '0;
        end else begin
            estado <= estado_sig;
            pc     <= pc_sig;
            if (inc_saltos && (cnt_saltos != '1)) begin
                cnt_saltos <= cnt_saltos + CNT_ONE;
            end
            if (inc_esperas && (cnt_esperas != '1)) begin
                cnt_esperas <= cnt_esperas + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_unidad_salto.sv
// tb/tb_unidad_salto.sv - table-driven self-checking bench for unidad_salto
module tb_unidad_salto;

    logic        clk = 1'b0;
    logic        reset;
    logic        Comparador_Salida, es_beq, es_bne, es_jump, operandos_listos, stall_ext;
    logic [31:0] pc_id, inmediato;
    logic [25:0] destino_j;
    logic [31:0] pc;
    logic        flush_if_id, stall_id;
    logic [3:0]  cnt_saltos, cnt_esperas;

    int n_cmp = 0;
    int n_bad = 0;

    unidad_salto #(.RESET_PC(32'h0000_0040), .CNT_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .Comparador_Salida (Comparador_Salida),
        .es_beq            (es_beq),
        .es_bne            (es_bne),
        .es_jump           (es_jump),
        .operandos_listos  (operandos_listos),
        .stall_ext         (stall_ext),
        .pc_id             (pc_id),
        .inmediato         (inmediato),
        .destino_j         (destino_j),
        .pc                (pc),
        .flush_if_id       (flush_if_id),
        .stall_id          (stall_id),
        .cnt_saltos        (cnt_saltos),
        .cnt_esperas       (cnt_esperas)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cmp, beq, bne, jmp, listos, sx;
        logic [31:0] pcid, inm;
        logic [25:0] dj;
        logic        e_flush, e_stall;
        logic [31:0] e_pc;
        logic [3:0]  e_cs, e_ce;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic cmp, logic beq, logic bne, logic jmp, logic listos,
                                logic sx, logic [31:0] pcid, logic [31:0] inm, logic [25:0] dj,
                                logic e_flush, logic e_stall, logic [31:0] e_pc,
                                logic [3:0] e_cs, logic [3:0] e_ce);
        vec_t v;
        v.cmp = cmp; v.beq = beq; v.bne = bne; v.jmp = jmp; v.listos = listos; v.sx = sx;
        v.pcid = pcid; v.inm = inm; v.dj = dj;
        v.e_flush = e_flush; v.e_stall = e_stall; v.e_pc = e_pc; v.e_cs = e_cs; v.e_ce = e_ce;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cmp, input logic beq, input logic bne, input logic jmp,
                         input logic listos, input logic sx, input logic [31:0] pcid,
                         input logic [31:0] inm, input logic [25:0] dj);
        Comparador_Salida = cmp; es_beq = beq; es_bne = bne; es_jump = jmp;
        operandos_listos = listos; stall_ext = sx; pc_id = pcid; inmediato = inm; destino_j = dj;
    endtask

    // Called at posedge+1: apply inputs, check combinational outputs mid-cycle,
    // then check registered state just after the next edge.
    task automatic apply(input string tag, input vec_t v);
        drive(v.cmp, v.beq, v.bne, v.jmp, v.listos, v.sx, v.pcid, v.inm, v.dj);
        #2;
        chk({tag, " flush"}, {31'd0, flush_if_id}, {31'd0, v.e_flush});
        chk({tag, " stall"}, {31'd0, stall_id}, {31'd0, v.e_stall});
        @(posedge clk); #1;
        chk({tag, " pc"}, pc, v.e_pc);
        chk({tag, " cnt_saltos"}, {28'd0, cnt_saltos}, {28'd0, v.e_cs});
        chk({tag, " cnt_esperas"}, {28'd0, cnt_esperas}, {28'd0, v.e_ce});
    endtask

    initial begin
        //              cmp beq bne jmp lst sx  pc_id          inm            dj           fl st pc             cs ce
        tbl[0]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         26'h0,       0, 0, 32'h0000_0044, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         26'h0,       0, 0, 32'h0000_0048, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         26'h0,       0, 0, 32'h0000_004C, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 1, 0, 32'h100,       32'hFFFF_FFFE, 26'h0,       1, 0, 32'h0000_00FC, 1, 0);
        tbl[4]  = mk(1, 0, 1, 0, 1, 0, 32'h100,       32'h10,        26'h0,       0, 0, 32'h0000_0100, 1, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1, 0, 32'hF000_0010, 32'h0,         26'h0000123, 1, 0, 32'hF000_048C, 2, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 32'h200,       32'h4,         26'h0,       0, 1, 32'hF000_048C, 2, 1);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 32'h200,       32'h4,         26'h0,       0, 1, 32'hF000_048C, 2, 2);
        tbl[8]  = mk(1, 1, 0, 0, 1, 0, 32'h200,       32'h4,         26'h0,       1, 0, 32'h0000_0214, 3, 2);
        tbl[9]  = mk(1, 1, 0, 0, 1, 1, 32'h300,       32'h4,         26'h0,       0, 0, 32'h0000_0214, 3, 2);
        tbl[10] = mk(1, 1, 0, 0, 1, 0, 32'h300,       32'h4,         26'h0,       1, 0, 32'h0000_0314, 4, 2);
        tbl[11] = mk(0, 0, 1, 0, 1, 0, 32'h400,       32'h1,         26'h0,       1, 0, 32'h0000_0408, 5, 2);
        tbl[12] = mk(0, 1, 0, 1, 1, 0, 32'h10,        32'h8,         26'h20,      1, 0, 32'h0000_0080, 6, 2);
        tbl[13] = mk(1, 1, 1, 0, 1, 0, 32'h80,        32'h0,         26'h0,       1, 0, 32'h0000_0084, 7, 2);
        tbl[14] = mk(0, 0, 0, 1, 1, 0, 32'hF000_0000, 32'h0,         26'h3FF_FFFF, 1, 0, 32'hFFFF_FFFC, 8, 2);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         26'h0,       0, 0, 32'h0000_0000, 8, 2);
        tbl[16] = mk(0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         26'h10,      1, 0, 32'h0000_0040, 9, 2);

        // Reset with a jump on the inputs: must not flush or stall while reset is high.
        reset = 1'b1;
        drive(0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 26'h10);
        @(posedge clk); #1;
        #1;
        chk("reset flush", {31'd0, flush_if_id}, 32'd0);
        chk("reset stall", {31'd0, stall_id}, 32'd0);
        chk("reset pc", pc, 32'h0000_0040);
        chk("reset cnt_saltos", {28'd0, cnt_saltos}, 32'd0);
        chk("reset cnt_esperas", {28'd0, cnt_esperas}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Saturation: 8 more jumps from cnt_saltos = 9 must stop at 0xF.
        for (int k = 0; k < 8; k++) begin
            logic [3:0] e_cs;
            e_cs = (9 + k + 1 > 15) ? 4'hF : 4'(9 + k + 1);
            apply($sformatf("sat%0d", k),
                  mk(0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 26'h10, 1, 0, 32'h0000_0040, e_cs, 2));
        end

        // Reset during ESPERA: enter the wait, then reset with the branch now resolvable.
        apply("wait", mk(1, 1, 0, 0, 0, 0, 32'h500, 32'h4, 26'h0, 0, 1, 32'h0000_0040, 4'hF, 3));
        reset = 1'b1;
        drive(1, 1, 0, 0, 1, 0, 32'h500, 32'h4, 26'h0);
        #2;
        chk("rst_wait flush", {31'd0, flush_if_id}, 32'd0);
        chk("rst_wait stall", {31'd0, stall_id}, 32'd0);
        @(posedge clk); #1;
        chk("rst_wait pc", pc, 32'h0000_0040);
        chk("rst_wait cnt_saltos", {28'd0, cnt_saltos}, 32'd0);
        chk("rst_wait cnt_esperas", {28'd0, cnt_esperas}, 32'd0);
        reset = 1'b0;
        apply("post_rst", mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h0000_0044, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
